// File: rtl/sram_serial_loader.sv
// sram_serial_loader: turns parallel {addr,data} write requests into the SRAM I/O controller's serial load protocol.
// Latency: accept edge + 21 cycles to DONE with a controller that raises IO_RDY two cycles after the last bit.
// Backpressure: WR_READY is high only in IDLE. The host holds WR_VALID/WR_ADDR/WR_DATA until it is accepted.
//
// Ports:
//   CLK, RST_N               clock and asynchronous active-low reset
//   WR_VALID/WR_READY        host request handshake carrying WR_ADDR, WR_DATA
//   CLR_ERR                  synchronous clear of the sticky ERR flag
//   IO_RDY                   ready flag returned by the I/O controller
//   IO_BGN, IO_LOAD_N, IO_SI controller begin (low = clear), load strobe (active low), serial data
//   BUSY, DONE, ERR          status: not idle, one-cycle word acknowledge, sticky IO_RDY timeout
//
// Optional build macro SRAM_LDR_AUTOINC_EN: an internal address counter replaces WR_ADDR.
// A request with WR_DATA==0 and WR_ADDR!=0 presets that counter and starts no transfer.
module sram_serial_loader #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH,
  parameter int RDY_TIMEOUT       = 15
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         WR_VALID,
  input  logic [MEMORY_ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [MEMORY_DATA_WIDTH-1:0] WR_DATA,
  output logic                         WR_READY,
  input  logic                         CLR_ERR,
  input  logic                         IO_RDY,
  output logic                         IO_BGN,
  output logic                         IO_LOAD_N,
  output logic                         IO_SI,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ERR
);

  localparam int CNT_W = $clog2(REG_BITS_WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_START, S_SHIFT, S_WAIT} state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic [REG_BITS_WIDTH-1:0]    shreg;
  logic [CNT_W-1:0]             bit_cnt;
  logic [7:0]                   tmo_cnt;
  logic [MEMORY_ADDR_WIDTH-1:0] word_addr;
  logic                         preset;
  logic                         accept;
  logic                         ack;
  logic                         timeout;

`ifdef SRAM_LDR_AUTOINC_EN
  logic [MEMORY_ADDR_WIDTH-1:0] addr_cnt;

  // A zero-data request to a non-zero address is a counter preset, not a write.
  assign preset    = WR_VALID && (state == S_IDLE) && (WR_DATA == '0) && (WR_ADDR != '0);
  assign word_addr = addr_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_cnt <= '0;
    end else if (preset) begin
      addr_cnt <= WR_ADDR;
    end else if (ack) begin
      addr_cnt <= addr_cnt + MEMORY_ADDR_WIDTH'(1);
    end
  end
`else
  assign preset    = 1'b0;
  assign word_addr = WR_ADDR;
`endif

  assign WR_READY = (state == S_IDLE);
  assign BUSY     = (state != S_IDLE);
  assign accept   = WR_VALID && WR_READY && !preset;
  assign ack      = (state == S_WAIT) && IO_RDY;
  // An acknowledge on the timeout edge takes priority, so timeout requires IO_RDY low.
  assign timeout  = (state == S_WAIT) && !IO_RDY && (tmo_cnt == 8'(RDY_TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_ARM;
      S_ARM:   state_nxt = S_START;
      S_START: state_nxt = S_SHIFT;
      S_SHIFT: if (bit_cnt == '0) state_nxt = S_WAIT;
      S_WAIT:  if (ack || timeout) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Controller-facing outputs are registered from the next state so they
  // line up exactly with the state they belong to.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      tmo_cnt   <= '0;
      IO_BGN    <= 1'b0;
      IO_LOAD_N <= 1'b1;
      IO_SI     <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      IO_BGN    <= (state_nxt != S_IDLE);
      IO_LOAD_N <= (state_nxt != S_START);
      DONE      <= ack;
      if (timeout) begin
        ERR <= 1'b1;
      end else if (CLR_ERR) begin
        ERR <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) shreg <= {word_addr, WR_DATA};
        end
        S_START: begin
          IO_SI   <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= CNT_W'(REG_BITS_WIDTH - 1);
        end
        S_SHIFT: begin
          if (bit_cnt == '0) begin
            IO_SI   <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            IO_SI   <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_serial_loader.sv
module tb_sram_serial_loader;

  logic       CLK;
  logic       RST_N;
  logic       WR_VALID;
  logic [8:0] WR_ADDR;
  logic [7:0] WR_DATA;
  logic       WR_READY;
  logic       CLR_ERR;
  logic       IO_RDY;
  logic       IO_BGN;
  logic       IO_LOAD_N;
  logic       IO_SI;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  sram_serial_loader #(
    .MEMORY_DATA_WIDTH(8),
    .MEMORY_ADDR_WIDTH(9),
    .RDY_TIMEOUT(15)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_VALID(WR_VALID), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .WR_READY(WR_READY), .CLR_ERR(CLR_ERR), .IO_RDY(IO_RDY), .IO_BGN(IO_BGN),
    .IO_LOAD_N(IO_LOAD_N), .IO_SI(IO_SI), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: after a load strobe, shifts in 17 bits LSB first and
  // writes data to address. IO_BGN low aborts any word in progress.
  logic [7:0]  mem [int];
  int          mcnt = 0;
  logic [16:0] msr  = '0;

  always @(negedge CLK) begin
    if (!IO_BGN) begin
      mcnt = 0;
    end else if (mcnt > 0) begin
      msr  = {IO_SI, msr[16:1]};
      mcnt = mcnt - 1;
      if (mcnt == 0) mem[int'(msr[16:8])] = msr[7:0];
    end else if (!IO_LOAD_N) begin
      mcnt = 17;
    end
  end

  function automatic int memrd(input int a);
    if (mem.exists(a)) return int'(mem[a]);
    return -1;
  endfunction

  typedef struct {
    logic [8:0]  addr;
    logic [7:0]  data;
    int          dly;      // WAIT cycle (1-based) with IO_RDY high; 0 = never
    bit          noise;    // IO_RDY high through ARM/START/SHIFT
    bit          clr;      // CLR_ERR on the timeout edge
    logic [16:0] word;     // expected serial word
    int          exp_done; // cycle after accept edge carrying DONE, -1 = none
    int          exp_end;  // first idle cycle after accept edge
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge CLK);
    while (!WR_READY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("wait_ready", WR_READY, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          done_cyc;
    int          done_n;
    int          end_cyc;
    int          lown;
    int          bgn_bad;
    logic        bgn_end;
    logic [16:0] w;
    wait_ready();
    WR_VALID = 1'b1;
    WR_ADDR  = v.addr;
    WR_DATA  = v.data;
    @(posedge CLK);
    #1;
    // Changing the bus after accept must not affect the word in flight.
    WR_VALID = 1'b0;
    WR_ADDR  = ~v.addr;
    WR_DATA  = ~v.data;
    done_cyc = -1; done_n = 0; end_cyc = -1; lown = 0; bgn_bad = 0; bgn_end = 1'b1; w = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (DONE) begin
        done_n++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (!IO_LOAD_N) lown++;
      if (k >= 2 && k <= 18) w[k-2] = IO_SI;
      if (end_cyc < 0 && !BUSY) begin
        end_cyc = k;
        bgn_end = IO_BGN;
      end
      if (end_cyc < 0 && BUSY && !IO_BGN) bgn_bad++;
      IO_RDY  = (v.dly != 0 && k == 18 + v.dly) || (v.noise && k <= 18);
      CLR_ERR = v.clr && (k == 33);
    end
    IO_RDY  = 1'b0;
    CLR_ERR = 1'b0;
    check($sformatf("v%0d_load_n_pulses", idx), lown, 1);
    check($sformatf("v%0d_serial_word", idx), w, v.word);
    check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d_done_count", idx), done_n, (v.exp_done < 0) ? 0 : 1);
    check($sformatf("v%0d_end_cycle", idx), end_cyc, v.exp_end);
    check($sformatf("v%0d_bgn_drop_while_busy", idx), bgn_bad, 0);
    check($sformatf("v%0d_bgn_at_end", idx), bgn_end, 1'b0);
    check($sformatf("v%0d_err", idx), ERR, v.exp_err);
    check($sformatf("v%0d_ctrl_mem", idx), memrd(int'(v.word[16:8])), int'(v.word[7:0]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int d1;
    int nd;
    logic rdy_at_done;

    //                addr    data   dly noise clr  word        done end err
    vecs[0] = '{9'h1A5, 8'h3C, 2,  1'b0, 1'b0, 17'h1A53C, 21,  21, 1'b0};
    vecs[1] = '{9'h0AA, 8'h55, 1,  1'b1, 1'b0, 17'h0AA55, 20,  20, 1'b0};
    vecs[2] = '{9'h0F0, 8'h0F, 15, 1'b0, 1'b0, 17'h0F00F, 34,  34, 1'b0};
    vecs[3] = '{9'h123, 8'h81, 0,  1'b0, 1'b0, 17'h12381, -1,  34, 1'b1};
    vecs[4] = '{9'h155, 8'hAA, 0,  1'b0, 1'b1, 17'h155AA, -1,  34, 1'b1};

    RST_N = 1'b0; WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0; CLR_ERR = 1'b0; IO_RDY = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {IO_BGN, IO_LOAD_N, IO_SI, DONE, ERR, BUSY, WR_READY}, 7'b0100001);
    RST_N = 1'b1;

`ifdef SRAM_LDR_AUTOINC_EN
    // Preset the address counter, then three writes walk across the wrap.
    wait_ready();
    WR_VALID = 1'b1; WR_ADDR = 9'h1FE; WR_DATA = 8'h00;
    @(posedge CLK);
    #1;
    WR_VALID = 1'b0;
    @(negedge CLK);
    check("preset_no_transfer", {BUSY, IO_BGN}, 2'b00);
    run_vec('{9'h000, 8'h11, 2, 1'b0, 1'b0, 17'h1FE11, 21, 21, 1'b0}, 10);
    run_vec('{9'h0AB, 8'h22, 2, 1'b0, 1'b0, 17'h1FF22, 21, 21, 1'b0}, 11);
    run_vec('{9'h0CD, 8'h33, 2, 1'b0, 1'b0, 17'h00033, 21, 21, 1'b0}, 12);
`else
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // ERR is sticky until cleared.
    @(negedge CLK);
    CLR_ERR = 1'b1;
    @(negedge CLK);
    CLR_ERR = 1'b0;
    check("clr_err", ERR, 1'b0);

    // Back-to-back with WR_VALID held: second word accepted in the DONE cycle.
    wait_ready();
    WR_VALID = 1'b1; WR_ADDR = 9'h000; WR_DATA = 8'hFF;
    @(posedge CLK);
    #1;
    WR_ADDR = 9'h1FF; WR_DATA = 8'h01;
    d0 = -1; d1 = -1; rdy_at_done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (DONE) begin
        if (d0 < 0) begin
          d0 = k;
          rdy_at_done = WR_READY;
        end else if (d1 < 0) begin
          d1 = k;
        end
      end
      if (k == 22) WR_VALID = 1'b0;
      IO_RDY = (k == 20) || (k == 42);
    end
    IO_RDY = 1'b0;
    check("b2b_done0_cycle", d0, 21);
    check("b2b_done1_cycle", d1, 43);
    check("b2b_ready_in_done", rdy_at_done, 1'b1);
    check("b2b_mem_000", memrd(32'h000), 32'hFF);
    check("b2b_mem_1ff", memrd(32'h1FF), 32'h01);

    // Reset during SHIFT bit 9 aborts the word.
    wait_ready();
    WR_VALID = 1'b1; WR_ADDR = 9'h0C3; WR_DATA = 8'h5A;
    @(posedge CLK);
    #1;
    WR_VALID = 1'b0;
    repeat (12) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("midreset_outputs", {IO_BGN, IO_LOAD_N, IO_SI, DONE, ERR, BUSY, WR_READY}, 7'b0100001);
    @(negedge CLK);
    RST_N  = 1'b1;
    IO_RDY = 1'b1;
    nd = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (DONE) nd++;
    end
    IO_RDY = 1'b0;
    check("midreset_no_done", nd, 0);
    check("midreset_no_write", memrd(32'h0C3), -1);
    run_vec('{9'h0C3, 8'h5A, 2, 1'b0, 1'b0, 17'h0C35A, 21, 21, 1'b0}, 20);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_serial_loader.md
Name: sram_serial_loader

Overview:
Upstream sequencer for the SRAM serial I/O controller. It accepts parallel address/data write requests from a host or test engine over a valid/ready handshake. It generates the controller's serial load protocol (begin/clear, load strobe, LSB-first serial word) and waits for the controller's ready flag. It reports completion and timeout per word, and one instance drives one SRAM I/O controller.

Parameters:
MEMORY_DATA_WIDTH, 8, data bits per SRAM word
MEMORY_ADDR_WIDTH, 9, SRAM address bits
REG_BITS_WIDTH, MEMORY_ADDR_WIDTH+MEMORY_DATA_WIDTH, serial word length
RDY_TIMEOUT, 15, max cycles spent in WAIT before an error is flagged (1..255)

Ports:
CLK  in  1  single clock, all logic on posedge
RST_N  in  1  asynchronous active-low reset
WR_VALID  in  1  host request valid
WR_ADDR  in  MEMORY_ADDR_WIDTH  target address
WR_DATA  in  MEMORY_DATA_WIDTH  write data
WR_READY  out  1  loader can accept a request
CLR_ERR  in  1  synchronous clear of ERR
IO_RDY  in  1  ready flag from the I/O controller
IO_BGN  out  1  controller begin; low holds the controller in idle/clear
IO_LOAD_N  out  1  controller load strobe, active low
IO_SI  out  1  serial data to the controller
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle pulse: word acknowledged by the controller
ERR  out  1  sticky: timeout waiting for IO_RDY

Behaviour:
- Reset (RST_N low, async): state=IDLE; IO_BGN=0, IO_LOAD_N=1, IO_SI=0, DONE=0, ERR=0, BUSY=0, WR_READY=1. Shift register and counters are cleared.
- Reset mid-operation aborts the word. IO_BGN=0 forces the controller back to idle, and no DONE is generated.
- All outputs are registered, except WR_READY and BUSY, which are decoded from state.
- Serial word = {WR_ADDR, WR_DATA}, captured on the accept edge (WR_VALID & WR_READY). Sent LSB first: WR_DATA[0] first, WR_ADDR[MSB] last.
- IDLE: IO_BGN=0, IO_LOAD_N=1, WR_READY=1. On accept, go to ARM.
- ARM (1 cycle): IO_BGN=1, IO_LOAD_N=1. Releases the controller's clear one cycle before the strobe. Next state is START.
- START (1 cycle): IO_LOAD_N=0. The controller samples the strobe at the end of this cycle. Next state is SHIFT, and the edge leaving START loads IO_SI=word[0] and bit counter=REG_BITS_WIDTH-1.
- SHIFT (exactly REG_BITS_WIDTH cycles): IO_LOAD_N=1, and IO_SI holds bit k during the k-th SHIFT cycle. Each edge shifts the word right and decrements the counter. The edge at counter=0 goes to WAIT and sets IO_SI=0.
- WAIT: IO_BGN=1, and a timeout counter increments every cycle.
  - IO_RDY sampled high: go to IDLE and pulse DONE in the first IDLE cycle.
  - Counter reaches RDY_TIMEOUT with IO_RDY low: set ERR, go to IDLE, no DONE.
  - IO_RDY high and timeout on the same edge: DONE wins, ERR is not set.
- Returning to IDLE drives IO_BGN=0, which clears the controller for the next word.
- Nominal latency with a compliant controller (RDY two cycles after the last bit): accept edge + 21 cycles to DONE (ARM 1 + START 1 + SHIFT 17 + WAIT 2). The next accept is possible in the DONE cycle, giving back-to-back throughput of 1 word per 22 cycles.
- WR_VALID while busy is ignored (WR_READY=0). The host must hold the request; WR_ADDR/WR_DATA changes after accept have no effect.
- IO_RDY high in IDLE/ARM/START/SHIFT is ignored.
- ERR is sticky until CLR_ERR. CLR_ERR and a new timeout on the same edge leave ERR set. ERR does not block new requests.

Optional Feature:
SRAM_LDR_AUTOINC_EN:
- Defined:
  - An internal address counter (MEMORY_ADDR_WIDTH bits, reset 0) replaces WR_ADDR, which is ignored.
  - The counter increments after each DONE and wraps from all-ones to 0. It does not increment on timeout.
  - A load of WR_DATA with WR_ADDR while WR_VALID is high and BUSY is low presets the counter: if WR_DATA==0 and WR_ADDR!=0, the counter takes WR_ADDR and no transfer starts.
- Undefined: WR_ADDR is used directly and no counter exists.

Test Plan:
- Reset, then WR_ADDR=0x1A5, WR_DATA=0x3C -> IO_SI over SHIFT = 0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1,1; IO_LOAD_N low exactly 1 cycle; IO_RDY returned 2 cycles after the last bit gives DONE at accept+21; a controller model writes 0x3C to 0x1A5.
- IO_RDY held low, RDY_TIMEOUT=15 -> ERR=1 after 15 WAIT cycles, no DONE, IO_BGN=0 the next cycle; CLR_ERR pulse clears ERR.
- Two back-to-back requests (0x000/0xFF, 0x1FF/0x01) with WR_VALID held -> second accepted in the DONE cycle; both words serialized correctly, 22-cycle spacing.
- RST_N asserted during SHIFT bit 9 -> IO_BGN=0 immediately (async), no DONE; the next request completes normally.
- IO_RDY asserted on the same edge as the timeout -> DONE=1, ERR=0.
- With SRAM_LDR_AUTOINC_EN: preset address to 0x1FE, then write 3 words -> addresses 0x1FE, 0x1FF, 0x000.
